// File: rtl/alu_pkg.sv
// Shared definitions for the external ALU and the shift-add multiply sequencer:
// ALU operation encoding, datapath width and sequencer state encoding.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD   = 3'b000;
  localparam alu_ctrl_t ALU_SUB   = 3'b001;
  localparam alu_ctrl_t ALU_AND   = 3'b010;
  localparam alu_ctrl_t ALU_OR    = 3'b011;
  localparam alu_ctrl_t ALU_SRL   = 3'b100;
  localparam alu_ctrl_t ALU_SLT   = 3'b101;
  localparam alu_ctrl_t ALU_PASSB = 3'b110;
  localparam alu_ctrl_t ALU_SLL   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHL,
    ST_SHR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential 32x32 shift-add multiplier (low word) that borrows a shared external ALU.
// Define MUL_EARLY_EXIT_EN to stop iterating once the remaining multiplier bits are zero.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT = '1;

  state_t             state, state_nx;
  logic [DATA_W-1:0]  acc, mcand, mplr;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  // The final SHR exits either after the 32nd iteration or, in the early-exit
  // build, once the shifted multiplier has no set bits left.
  assign last_iter = (cnt == LAST_CNT) || (EARLY_EXIT && alu_zero);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (EARLY_EXIT && (op_b == '0)) state_nx = ST_DONE;
          else if (op_b[0])               state_nx = ST_ADD;
          else                            state_nx = ST_SHL;
        end
      end
      ST_ADD: if (alu_gnt) state_nx = ST_SHL;
      ST_SHL: if (alu_gnt) state_nx = ST_SHR;
      ST_SHR: begin
        if (alu_gnt) begin
          if (last_iter)          state_nx = ST_DONE;
          else if (alu_result[0]) state_nx = ST_ADD;
          else                    state_nx = ST_SHL;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ALU operands come straight from held registers, so a withheld grant keeps them stable.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    case (state)
      ST_ADD: begin
        busy     = 1'b1;
        alu_a    = acc;
        alu_b    = mcand;
        alu_ctrl = ALU_ADD;
      end
      ST_SHL: begin
        busy     = 1'b1;
        alu_a    = mcand;
        alu_b    = ONE;
        alu_ctrl = ALU_SLL;
      end
      ST_SHR: begin
        busy     = 1'b1;
        alu_a    = mplr;
        alu_b    = ONE;
        alu_ctrl = ALU_SRL;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    alu_req = busy;
  end

  // Product is written on entry to DONE so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= op_a;
            mplr  <= op_b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ST_ADD: if (alu_gnt) acc <= alu_result;
        ST_SHL: if (alu_gnt) mcand <= alu_result;
        ST_SHR: begin
          if (alu_gnt) begin
            mplr <= alu_result;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if ((state != ST_DONE) && (state_nx == ST_DONE))
        product <= (state == ST_IDLE) ? '0 : acc;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared ALU.
// Expected latencies follow the MUL_EARLY_EXIT_EN setting of the build.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, alu_gnt;
  logic [31:0] op_a, op_b;
  logic        busy, done, alu_req, alu_zero;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;

  int errors = 0;
  int checks = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam int BUSY_7_5   = 8;
  localparam int BUSY_FF    = 96;
  localparam int BUSY_ZERO  = 0;
  localparam int BUSY_3_3   = 11;
  localparam int BUSY_6_7   = 9;
  localparam int BUSY_2_2   = 5;
  localparam int BUSY_64K   = 35;
  localparam int BUSY_NEG   = 8;
  localparam int RST_WAIT   = 4;
`else
  localparam int BUSY_7_5   = 66;
  localparam int BUSY_FF    = 96;
  localparam int BUSY_ZERO  = 64;
  localparam int BUSY_3_3   = 71;
  localparam int BUSY_6_7   = 67;
  localparam int BUSY_2_2   = 65;
  localparam int BUSY_64K   = 65;
  localparam int BUSY_NEG   = 66;
  localparam int RST_WAIT   = 20;
`endif

  alu_mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  // Shared ALU model
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD:   alu_result = alu_a + alu_b;
      ALU_SUB:   alu_result = alu_a - alu_b;
      ALU_AND:   alu_result = alu_a & alu_b;
      ALU_OR:    alu_result = alu_a | alu_b;
      ALU_SRL:   alu_result = alu_a >> alu_b[4:0];
      ALU_SLT:   alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_PASSB: alu_result = alu_b;
      ALU_SLL:   alu_result = alu_a << alu_b[4:0];
      default:   alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(output int nb, output int nreq, output int ncyc,
                             output bit seen, output logic [31:0] prod);
    nb = 0; nreq = 0; ncyc = 0; seen = 1'b0; prod = '0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      ncyc++;
      if (busy) nb++;
      if (alu_req) nreq++;
      if (done) begin
        seen = 1'b1;
        prod = product;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op_a = 32'd5; op_b = 32'd5; alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (alu_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", alu_req); end
    checks++; if (product !== 32'd0) begin errors++; $display("FAIL reset_product: got %h want 0", product); end
    checks++; if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin errors++; $display("FAIL reset_alu_bus: got %h %h %b want 0", alu_a, alu_b, alu_ctrl); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expp, input int expb, input string nm);
    int nb, nreq, ncyc;
    bit seen;
    logic [31:0] prod;
    accept(a, b);
    run_to_done(nb, nreq, ncyc, seen, prod);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL %s_done_seen: got %b want 1", nm, seen); end
    checks++; if (prod !== expp) begin errors++; $display("FAIL %s_product: got %h want %h", nm, prod, expp); end
    checks++; if (nb !== expb) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", nm, nb, expb); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b want 0", nm, done); end
    checks++; if ({alu_req, alu_a, alu_b, alu_ctrl} !== 68'd0) begin errors++; $display("FAIL %s_idle_alu_bus: got %b %h %h %b want 0", nm, alu_req, alu_a, alu_b, alu_ctrl); end
    checks++; if (product !== expp) begin errors++; $display("FAIL %s_product_hold: got %h want %h", nm, product, expp); end
  endtask

  task automatic test_zero_multiplier();
    int nb, nreq, ncyc;
    bit seen;
    logic [31:0] prod;
    accept(32'h0000_1234, 32'd0);
    run_to_done(nb, nreq, ncyc, seen, prod);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL zero_done_seen: got %b want 1", seen); end
    checks++; if (prod !== 32'd0) begin errors++; $display("FAIL zero_product: got %h want 0", prod); end
    checks++; if (nb !== BUSY_ZERO) begin errors++; $display("FAIL zero_busy_cycles: got %0d want %0d", nb, BUSY_ZERO); end
`ifdef MUL_EARLY_EXIT_EN
    checks++; if (ncyc !== 1) begin errors++; $display("FAIL zero_done_latency: got %0d want 1", ncyc); end
    checks++; if (nreq !== 0) begin errors++; $display("FAIL zero_alu_req_cycles: got %0d want 0", nreq); end
`else
    checks++; if (nreq !== 64) begin errors++; $display("FAIL zero_alu_req_cycles: got %0d want 64", nreq); end
`endif
  endtask

  task automatic test_stall();
    int nb, nreq, ncyc, pre;
    bit seen;
    logic [31:0] prod;
    pre = 0;
    accept(32'd3, 32'd3);
    alu_gnt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) pre++;
      checks++;
      if (alu_a !== 32'd0 || alu_b !== 32'd3 || alu_ctrl !== ALU_ADD || alu_req !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_frozen_%0d: got a=%h b=%h ctrl=%b req=%b done=%b want a=0 b=3 ctrl=000 req=1 done=0",
                 k, alu_a, alu_b, alu_ctrl, alu_req, done);
      end
    end
    alu_gnt = 1'b1;
    run_to_done(nb, nreq, ncyc, seen, prod);
    checks++; if (prod !== 32'd9) begin errors++; $display("FAIL stall_product: got %h want 9", prod); end
    checks++; if (pre + nb !== BUSY_3_3) begin errors++; $display("FAIL stall_busy_cycles: got %0d want %0d", pre + nb, BUSY_3_3); end
  endtask

  task automatic test_reset_mid_op();
    int dones, busys;
    dones = 0; busys = 0;
    accept(32'd9, 32'd9);
    repeat (RST_WAIT) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (product !== 32'd0) begin errors++; $display("FAIL midrst_product: got %h want 0", product); end
    checks++; if (alu_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", alu_req); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busys++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
    checks++; if (busys !== 0) begin errors++; $display("FAIL midrst_stays_idle: got %0d want 0", busys); end
    test_mul(32'd6, 32'd7, 32'd42, BUSY_6_7, "after_rst");
  endtask

  task automatic test_start_while_busy();
    int nb, ndone, late;
    bit seen;
    logic [31:0] prod;
    nb = 0; ndone = 0; late = 0; seen = 1'b0; prod = '0;
    accept(32'd2, 32'd2);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin seen = 1'b1; prod = product; end
      if (i == 1) begin start = 1'b1; op_a = 32'd100; op_b = 32'd100; end
      if (i == 3) start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || done) late++;
    end
    checks++; if (prod !== 32'd4) begin errors++; $display("FAIL ignore_product: got %h want 4", prod); end
    checks++; if (nb !== BUSY_2_2) begin errors++; $display("FAIL ignore_busy_cycles: got %0d want %0d", nb, BUSY_2_2); end
    checks++; if (late !== 0) begin errors++; $display("FAIL ignore_no_queue: got %0d want 0", late); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; alu_gnt = 1'b1;
    test_reset();
    test_mul(32'd7, 32'd5, 32'd35, BUSY_7_5, "mul_7x5");
    test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, BUSY_FF, "mul_allones");
    test_zero_multiplier();
    test_mul(32'h0001_0000, 32'h0001_0000, 32'd0, BUSY_64K, "mul_wrap");
    test_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, BUSY_NEG, "mul_neg3x5");
    test_stall();
    test_reset_mid_op();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
